imem_boot_loader: RTL and testbench

//  Loads a program image into instruction memory from a byte stream, holding the CPU in reset meanwhile.

---
 rtl/imem_boot_loader.sv | 152 +++++++++++++++
 tb/tb_imem_boot_loader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Streams a length-prefixed little-endian program image into instruction memory,
// holding the CPU in reset until the whole image has been consumed.
module imem_boot_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 1024,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic                  o_rx_ready,
    input  logic                  i_reload,
    output logic                  o_imem_we,
    output logic [ADDR_WIDTH-1:0] o_imem_addr,
    output logic [DATA_WIDTH-1:0] o_imem_wdata,
    output logic                  o_cpu_reset_n,
    output logic                  o_busy,
    output logic                  o_error
);

    typedef enum logic [1:0] {
        S_LEN_LO = 2'd0,
        S_LEN_HI = 2'd1,
        S_DATA   = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [15:0]             len_q, len_d;
    logic [1:0]              byte_idx_q, byte_idx_d;
    logic [15:0]             word_cnt_q, word_cnt_d;
    logic [23:0]             part_q, part_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    error_q, error_d;
    logic                    cpu_rst_n_q, cpu_rst_n_d;

    logic                    accept;
    logic                    word_done;
    logic                    last_word;
    logic                    in_range;
    logic [15:0]             word_cnt_inc;

    assign accept       = i_rx_valid && o_rx_ready;
    assign word_done    = (byte_idx_q == 2'd3);
    assign word_cnt_inc = word_cnt_q + 16'd1;
    assign last_word    = (word_cnt_inc == len_q);
    assign in_range     = ({16'd0, word_cnt_q} < 32'(MEM_WORDS));

    // State register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_LEN_LO;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LEN_LO: if (accept) state_d = S_LEN_HI;
            S_LEN_HI: if (accept) state_d = ({i_rx_data, len_q[7:0]} == 16'd0) ? S_DONE : S_DATA;
            S_DATA:   if (accept && word_done && last_word) state_d = S_DONE;
            S_DONE:   if (i_reload) state_d = S_LEN_LO;
            default:  state_d = S_LEN_LO;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        o_rx_ready = (state_q != S_DONE);
        o_busy     = (state_q != S_DONE);
    end

    always_comb begin
        len_d       = len_q;
        byte_idx_d  = byte_idx_q;
        word_cnt_d  = word_cnt_q;
        part_d      = part_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        error_d     = error_q;
        // Release follows DONE by one edge; a reload pulls it straight back low.
        cpu_rst_n_d = (state_q == S_DONE) && !i_reload;
        case (state_q)
            S_LEN_LO: if (accept) len_d[7:0] = i_rx_data;
            S_LEN_HI: if (accept) len_d[15:8] = i_rx_data;
            S_DATA: begin
                if (accept) begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    part_d     = {i_rx_data, part_q[23:8]};
                    if (word_done) begin
                        word_cnt_d = word_cnt_inc;
                        if (in_range) begin
                            we_d    = 1'b1;
                            addr_d  = ADDR_WIDTH'({word_cnt_q, 2'b00});
                            wdata_d = DATA_WIDTH'({i_rx_data, part_q});
                        end else begin
                            error_d = 1'b1;
                        end
                    end
                end
            end
            S_DONE: begin
                if (i_reload) begin
                    len_d      = 16'd0;
                    byte_idx_d = 2'd0;
                    word_cnt_d = 16'd0;
                    part_d     = 24'd0;
                    error_d    = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            len_q       <= 16'd0;
            byte_idx_q  <= 2'd0;
            word_cnt_q  <= 16'd0;
            part_q      <= 24'd0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            error_q     <= 1'b0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            len_q       <= len_d;
            byte_idx_q  <= byte_idx_d;
            word_cnt_q  <= word_cnt_d;
            part_q      <= part_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            error_q     <= error_d;
            cpu_rst_n_q <= cpu_rst_n_d;
        end
    end

    assign o_imem_we     = we_q;
    assign o_imem_addr   = addr_q;
    assign o_imem_wdata  = wdata_q;
    assign o_error       = error_q;
    assign o_cpu_reset_n = cpu_rst_n_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: table of fixed images, reset/reload corner cases,
// then random images checked against a write-list model built from the image rules.
module tb_imem_boot_loader;

    localparam int MEM_WORDS  = 4;
    localparam int ADDR_WIDTH = 12;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic [7:0]  i_rx_data = 8'd0;
    logic        i_rx_valid = 1'b0;
    logic        i_reload = 1'b0;
    logic        o_rx_ready;
    logic        o_imem_we;
    logic [11:0] o_imem_addr;
    logic [31:0] o_imem_wdata;
    logic        o_cpu_reset_n;
    logic        o_busy;
    logic        o_error;

    imem_boot_loader #(
        .DATA_WIDTH(32),
        .MEM_WORDS (MEM_WORDS),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_rx_data    (i_rx_data),
        .i_rx_valid   (i_rx_valid),
        .o_rx_ready   (o_rx_ready),
        .i_reload     (i_reload),
        .o_imem_we    (o_imem_we),
        .o_imem_addr  (o_imem_addr),
        .o_imem_wdata (o_imem_wdata),
        .o_cpu_reset_n(o_cpu_reset_n),
        .o_busy       (o_busy),
        .o_error      (o_error)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t         obs_q[$];
    int          rel_q[$];
    int          wdata_glitch = 0;
    logic        prev_rel = 1'b0;
    logic [31:0] prev_wdata = 32'd0;

    // Observer: records every strobe and each CPU release edge, flags wdata moving without a strobe.
    always @(negedge i_clk) begin
        if (i_reset_n) begin
            if (o_imem_we)
                obs_q.push_back('{addr: o_imem_addr, data: o_imem_wdata, cyc: cyc});
            else if (o_imem_wdata !== prev_wdata)
                wdata_glitch++;
            if (o_cpu_reset_n && !prev_rel)
                rel_q.push_back(cyc);
        end
        prev_rel   = o_cpu_reset_n;
        prev_wdata = o_imem_wdata;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int rnd_gap(input int gap_max);
        return (gap_max == 0) ? 0 : int'($urandom_range(0, gap_max));
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap, output int acc_cyc);
        int t;
        i_rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge i_clk);
            #1;
        end
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        t = 0;
        while (!o_rx_ready && t < 20) begin
            @(posedge i_clk);
            #1;
            t++;
        end
        if (!o_rx_ready) check("rx_ready_timeout", 64'd0, 64'd1);
        @(posedge i_clk);
        #1;
        acc_cyc    = cyc;
        i_rx_valid = 1'b0;
        $display("byte 0x%02h accepted at cycle %0d", b, acc_cyc);
    endtask

    task automatic do_reload();
        i_reload = 1'b1;
        @(posedge i_clk);
        #1;
        i_reload = 1'b0;
        check("reload_cpu_reset_n", 64'(o_cpu_reset_n), 64'd0);
        check("reload_error", 64'(o_error), 64'd0);
        check("reload_busy", 64'(o_busy), 64'd1);
    endtask

    // Sends one image and checks the resulting write list, error flag and release timing.
    task automatic run_load(input string tag, input int n, input logic [5:0][31:0] w,
                            input int gap_max, input bit reload_mid, output int base);
        wr_t         exp_q[$];
        int          acc, last_acc, rel_base, t, got, rel;
        logic [31:0] word;
        base     = obs_q.size();
        rel_base = rel_q.size();
        send_byte(n[7:0], rnd_gap(gap_max), acc);
        send_byte(n[15:8], rnd_gap(gap_max), acc);
        last_acc = acc;
        for (int wi = 0; wi < n; wi++) begin
            word = w[wi];
            for (int k = 0; k < 4; k++) begin
                send_byte(word[8*k +: 8], rnd_gap(gap_max), acc);
                last_acc = acc;
                if (reload_mid && wi == 0 && k == 1) begin
                    i_reload = 1'b1;
                    @(posedge i_clk);
                    #1;
                    i_reload = 1'b0;
                end
            end
            if (wi < MEM_WORDS) exp_q.push_back('{addr: 12'(wi * 4), data: word, cyc: last_acc});
        end
        t = 0;
        while (!o_cpu_reset_n && t < 20) begin
            @(posedge i_clk);
            #1;
            t++;
        end
        @(negedge i_clk);
        #1;
        got = obs_q.size() - base;
        $display("load %s: N=%0d strobes=%0d expected=%0d error=%0b", tag, n, got, exp_q.size(), o_error);
        check({tag, "_strobe_count"}, 64'(got), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got; i++) begin
            check({tag, "_addr"}, 64'(obs_q[base + i].addr), 64'(exp_q[i].addr));
            check({tag, "_data"}, 64'(obs_q[base + i].data), 64'(exp_q[i].data));
            check({tag, "_strobe_cycle"}, 64'(obs_q[base + i].cyc), 64'(exp_q[i].cyc));
        end
        rel = (rel_q.size() > rel_base) ? rel_q[rel_base] : -1;
        check({tag, "_release_cycle"}, 64'(rel), 64'(last_acc + 1));
        check({tag, "_error"}, 64'(o_error), 64'(n > MEM_WORDS));
        check({tag, "_ready_done"}, 64'(o_rx_ready), 64'd0);
        check({tag, "_busy_done"}, 64'(o_busy), 64'd0);
    endtask

    typedef struct {
        string            name;
        int               n;
        int               gap_max;
        bit               reload_mid;
        logic [5:0][31:0] w;
        int               exp_strobes;
        bit               exp_err;
        logic [31:0]      exp_w0;
        logic [31:0]      exp_w1;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int               base, acc, n;
        logic [5:0][31:0] rw;

        vecs[0] = '{"n2_stream", 2, 0, 1'b0,
                    {32'h0, 32'h0, 32'h0, 32'h0, 32'h401282B3, 32'h00100133},
                    2, 1'b0, 32'h00100133, 32'h401282B3};
        vecs[1] = '{"n2_gaps", 2, 5, 1'b0,
                    {32'h0, 32'h0, 32'h0, 32'h0, 32'h401282B3, 32'h00100133},
                    2, 1'b0, 32'h00100133, 32'h401282B3};
        vecs[2] = '{"n0_empty", 0, 2, 1'b0,
                    {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
                    0, 1'b0, 32'h0, 32'h0};
        vecs[3] = '{"n6_overflow", 6, 1, 1'b0,
                    {32'h66666666, 32'h55555555, 32'hC4C3C2C1, 32'hB4B3B2B1, 32'hA4A3A2A1, 32'h04030201},
                    4, 1'b1, 32'h04030201, 32'hA4A3A2A1};
        vecs[4] = '{"n1_reload_in_data", 1, 1, 1'b1,
                    {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF},
                    1, 1'b0, 32'hDEADBEEF, 32'h0};

        repeat (3) @(posedge i_clk);
        #1;
        check("rst_we", 64'(o_imem_we), 64'd0);
        check("rst_addr", 64'(o_imem_addr), 64'd0);
        check("rst_wdata", 64'(o_imem_wdata), 64'd0);
        check("rst_error", 64'(o_error), 64'd0);
        check("rst_cpu_reset_n", 64'(o_cpu_reset_n), 64'd0);
        check("rst_ready", 64'(o_rx_ready), 64'd1);
        check("rst_busy", 64'(o_busy), 64'd1);
        i_reset_n = 1'b1;
        @(posedge i_clk);
        #1;

        for (int v = 0; v < 5; v++) begin
            if (v != 0) do_reload();
            run_load(vecs[v].name, vecs[v].n, vecs[v].w, vecs[v].gap_max, vecs[v].reload_mid, base);
            check({vecs[v].name, "_table_strobes"}, 64'(obs_q.size() - base), 64'(vecs[v].exp_strobes));
            check({vecs[v].name, "_table_error"}, 64'(o_error), 64'(vecs[v].exp_err));
            if (vecs[v].exp_strobes >= 1 && obs_q.size() > base)
                check({vecs[v].name, "_table_w0"}, 64'(obs_q[base].data), 64'(vecs[v].exp_w0));
            if (vecs[v].exp_strobes >= 2 && obs_q.size() > base + 1)
                check({vecs[v].name, "_table_w1"}, 64'(obs_q[base + 1].data), 64'(vecs[v].exp_w1));
        end

        // Asynchronous reset after two bytes of word 1
        do_reload();
        send_byte(8'h02, 0, acc);
        send_byte(8'h00, 0, acc);
        send_byte(8'h11, 0, acc);
        send_byte(8'h22, 0, acc);
        send_byte(8'h33, 0, acc);
        send_byte(8'h44, 0, acc);
        send_byte(8'h55, 0, acc);
        send_byte(8'h66, 0, acc);
        #2;
        i_reset_n = 1'b0;
        #1;
        $display("async reset asserted mid-load at cycle %0d", cyc);
        check("midrst_we", 64'(o_imem_we), 64'd0);
        check("midrst_addr", 64'(o_imem_addr), 64'd0);
        check("midrst_wdata", 64'(o_imem_wdata), 64'd0);
        check("midrst_cpu_reset_n", 64'(o_cpu_reset_n), 64'd0);
        check("midrst_busy", 64'(o_busy), 64'd1);
        repeat (2) @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        run_load("after_reset", 2, {32'h0, 32'h0, 32'h0, 32'h0, 32'h401282B3, 32'h00100133}, 0, 1'b0, base);
        if (obs_q.size() > base + 1) begin
            check("after_reset_w0", 64'(obs_q[base].data), 64'h00100133);
            check("after_reset_w1", 64'(obs_q[base + 1].data), 64'h401282B3);
        end else begin
            check("after_reset_strobes_present", 64'(obs_q.size() - base), 64'd2);
        end

        for (int r = 0; r < 8; r++) begin
            do_reload();
            n = int'($urandom_range(0, 6));
            for (int i = 0; i < 6; i++) rw[i] = $urandom;
            run_load("random", n, rw, 3, 1'($urandom_range(0, 1)), base);
        end

        check("wdata_stable_without_we", 64'(wdata_glitch), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
